// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: control-flow redirect sequencer between branch
// resolution and fetch, with an optional 2-bit saturating BHT that gives
// fetch a taken/not-taken hint.
// Optional feature macro: BHT_EN (BHT present). When it is undefined, the
// hint is tied to 0 and the resolve-side hint is treated as 0.
module branch_redirect_ctrl #(
   parameter int WIDTH_PC  = 32,
   parameter int BHT_IDX_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH_PC-1:0] pc_IF,
   output logic                predTaken,
   input  logic                resolveValid,
   input  logic                resolveIsCond,
   input  logic [WIDTH_PC-1:0] resolvePC,
   input  logic                resolvePredTaken,
   input  logic                PCSel,
   input  logic [WIDTH_PC-1:0] branchPC,
   input  logic                fetchReady,
   output logic                redirectValid,
   output logic [WIDTH_PC-1:0] redirectPC,
   output logic                flush,
   output logic                stall
);

   typedef enum logic {IDLE, REDIRECT} state_t;

   state_t              state;
   state_t              state_next;
   logic [WIDTH_PC-1:0] redirect_pc_q;
   logic [WIDTH_PC-1:0] target;
   logic                hint;
   logic                mispredict;
   logic                unused_bits;

`ifdef BHT_EN
   localparam int unsigned BHT_DEPTH = 1 << BHT_IDX_W;

   logic [1:0]           bht [BHT_DEPTH];
   logic [BHT_IDX_W-1:0] fetch_idx;
   logic [BHT_IDX_W-1:0] resolve_idx;

   assign fetch_idx   = pc_IF[BHT_IDX_W+1:2];
   assign resolve_idx = resolvePC[BHT_IDX_W+1:2];
   assign predTaken   = bht[fetch_idx][1];
   assign hint        = resolvePredTaken;

   // BHT: bulk init on reset, saturating update for conditional branches in IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
            bht[BHT_IDX_W'(i)] <= 2'b01;
         end
      end else if ((state == IDLE) && resolveValid && resolveIsCond) begin
         if (PCSel) begin
            if (bht[resolve_idx] != 2'b11) begin
               bht[resolve_idx] <= bht[resolve_idx] + 2'b01;
            end
         end else begin
            if (bht[resolve_idx] != 2'b00) begin
               bht[resolve_idx] <= bht[resolve_idx] - 2'b01;
            end
         end
      end
   end
`else
   assign predTaken = 1'b0;
   assign hint      = 1'b0;
`endif

   // pc_IF and the carried hint are only consumed when the BHT is built in
   assign unused_bits = ^{pc_IF, resolvePredTaken};

   assign mispredict = resolveValid & (~resolveIsCond | (PCSel ^ hint));
   assign target     = (resolveIsCond & ~PCSel) ? (resolvePC + WIDTH_PC'(4))
                                                : branchPC;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: enter REDIRECT on mispredict, leave on fetch handshake
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:     if (mispredict) state_next = REDIRECT;
         REDIRECT: if (fetchReady) state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Redirect PC capture; cleared when the handshake completes
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_pc_q <= '0;
      end else if ((state == IDLE) && mispredict) begin
         redirect_pc_q <= target;
      end else if ((state == REDIRECT) && fetchReady) begin
         redirect_pc_q <= '0;
      end
   end

   // Outputs are a pure function of state
   always_comb begin
      redirectValid = (state == REDIRECT);
      flush         = (state == REDIRECT);
      stall         = (state == REDIRECT);
      redirectPC    = redirect_pc_q;
   end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all cross-checked every cycle against a behavioural
// model (pending flag, held target, integer saturating counters).
module tb_branch_redirect_ctrl;

`ifdef BHT_EN
   localparam bit BHT = 1'b1;
`else
   localparam bit BHT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_IF;
   logic        predTaken;
   logic        resolveValid;
   logic        resolveIsCond;
   logic [31:0] resolvePC;
   logic        resolvePredTaken;
   logic        PCSel;
   logic [31:0] branchPC;
   logic        fetchReady;
   logic        redirectValid;
   logic [31:0] redirectPC;
   logic        flush;
   logic        stall;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   branch_redirect_ctrl #(.WIDTH_PC(32), .BHT_IDX_W(6)) dut (
      .clk(clk), .rst(rst), .pc_IF(pc_IF), .predTaken(predTaken),
      .resolveValid(resolveValid), .resolveIsCond(resolveIsCond),
      .resolvePC(resolvePC), .resolvePredTaken(resolvePredTaken),
      .PCSel(PCSel), .branchPC(branchPC), .fetchReady(fetchReady),
      .redirectValid(redirectValid), .redirectPC(redirectPC),
      .flush(flush), .stall(stall)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          m_pend;
   logic [31:0] m_rpc;
   int          m_bht [64];
   logic        m_hint;

   assign m_hint = BHT ? resolvePredTaken : 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_pend <= 1'b0;
         m_rpc  <= 32'h0;
         for (int i = 0; i < 64; i++) m_bht[i] <= 1;
      end else if (m_pend) begin
         if (fetchReady) begin
            m_pend <= 1'b0;
            m_rpc  <= 32'h0;
         end
      end else if (resolveValid) begin
         if (!resolveIsCond || (PCSel != m_hint)) begin
            m_pend <= 1'b1;
            m_rpc  <= (resolveIsCond && !PCSel) ? resolvePC + 32'd4 : branchPC;
         end
         if (resolveIsCond && BHT) begin
            if (PCSel) m_bht[resolvePC[7:2]] <= (m_bht[resolvePC[7:2]] >= 3) ? 3 : m_bht[resolvePC[7:2]] + 1;
            else       m_bht[resolvePC[7:2]] <= (m_bht[resolvePC[7:2]] <= 0) ? 0 : m_bht[resolvePC[7:2]] - 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   // Compare process: DUT against model on every falling edge
   always @(negedge clk) begin
      if (check_en) begin
         chk("model_redirectValid", {31'b0, redirectValid}, {31'b0, m_pend});
         chk("model_flush",         {31'b0, flush},         {31'b0, m_pend});
         chk("model_stall",         {31'b0, stall},         {31'b0, m_pend});
         chk("model_redirectPC",    redirectPC,             m_rpc);
         chk("model_predTaken",     {31'b0, predTaken},
             {31'b0, (BHT && (m_bht[pc_IF[7:2]] >= 2))});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      resolveValid = 1'b0; resolveIsCond = 1'b0; resolvePC = '0;
      resolvePredTaken = 1'b0; PCSel = 1'b0; branchPC = '0;
   endtask

   // One resolve cycle; returns one tick after the capturing edge
   task automatic resolve(input bit cond, input logic [31:0] pc, input bit hnt,
                          input bit sel, input logic [31:0] tgt, input bit fr);
      resolveValid = 1'b1; resolveIsCond = cond; resolvePC = pc;
      resolvePredTaken = hnt; PCSel = sel; branchPC = tgt; fetchReady = fr;
      cyc();
      quiet();
   endtask

   task automatic settle();
      fetchReady = 1'b1;
      cyc();
      cyc();
   endtask

   task automatic pred_at(input string name, input logic [31:0] pc, input bit exp);
      pc_IF = pc;
      #1;
      chk(name, {31'b0, predTaken}, {31'b0, exp});
   endtask

   initial begin
      quiet();
      pc_IF = '0; fetchReady = 1'b0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_en = 1'b1;

      // 1: reset state
      pred_at("rst_pred_0x0",   32'h0,   1'b0);
      pred_at("rst_pred_0x100", 32'h100, 1'b0);
      pred_at("rst_pred_0xFFC", 32'hFFC, 1'b0);
      chk("rst_redirectValid", {31'b0, redirectValid}, 32'h0);
      chk("rst_flush_stall",   {30'b0, flush, stall},  32'h0);
      chk("rst_redirectPC",    redirectPC,             32'h0);

      // 2: taken branch predicted not-taken, twice
      resolve(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b1);
      chk("t2_valid", {29'b0, redirectValid, flush, stall}, 32'h7);
      chk("t2_pc",    redirectPC, 32'h200);
      cyc();
      chk("t2_idle",  {31'b0, redirectValid}, 32'h0);
      cyc();
      resolve(1'b1, 32'h100, 1'b0, 1'b1, 32'h200, 1'b1);
      chk("t2b_pc", redirectPC, 32'h200);
      settle();
      pred_at("t2_pred_0x100", 32'h100, BHT);

      // 3: not-taken branch predicted taken, including wrap
      resolve(1'b1, 32'h100, 1'b1, 1'b0, 32'h0BAD, 1'b1);
      chk("t3_valid", {31'b0, redirectValid}, {31'b0, BHT});
      chk("t3_pc",    redirectPC, BHT ? 32'h104 : 32'h0);
      settle();
      resolve(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0BAD, 1'b1);
      chk("t3_wrap_valid", {31'b0, redirectValid}, {31'b0, BHT});
      chk("t3_wrap_pc",    redirectPC, 32'h0);
      settle();

      // 4: jalr always redirects and leaves the BHT alone
      resolve(1'b0, 32'h80, 1'b0, 1'b1, 32'h3000, 1'b1);
      chk("t4_jalr_valid", {31'b0, redirectValid}, 32'h1);
      chk("t4_jalr_pc",    redirectPC, 32'h3000);
      settle();
      pred_at("t4_pred_0x80", 32'h80, 1'b0);
      resolve(1'b1, 32'h40, 1'b1, 1'b1, 32'h444, 1'b1);
      chk("t4_correct_valid", {31'b0, redirectValid}, {31'b0, !BHT});
      settle();

      // 5: fetch back-pressure with ignored resolves
      resolve(1'b1, 32'h200, 1'b0, 1'b1, 32'h500, 1'b0);
      for (int k = 0; k < 3; k++) begin
         chk("t5_hold_valid", {29'b0, redirectValid, flush, stall}, 32'h7);
         chk("t5_hold_pc",    redirectPC, 32'h500);
         resolveValid = 1'b1; resolveIsCond = 1'b1; resolvePC = 32'h200;
         resolvePredTaken = 1'b1; PCSel = 1'b0; branchPC = 32'h999;
         cyc();
      end
      quiet();
      chk("t5_still_pc", redirectPC, 32'h500);
      fetchReady = 1'b1;
      cyc();
      chk("t5_released", {31'b0, redirectValid}, 32'h0);
      pred_at("t5_pred_0x200", 32'h200, BHT);
      cyc();

      // 6: reset mid-redirect, then saturation
      resolve(1'b0, 32'h80, 1'b0, 1'b1, 32'h3000, 1'b0);
      chk("t6_in_redirect", {31'b0, redirectValid}, 32'h1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t6_rst_outs", {29'b0, redirectValid, flush, stall}, 32'h0);
      chk("t6_rst_pc",   redirectPC, 32'h0);
      pred_at("t6_rst_pred_0x100", 32'h100, 1'b0);
      for (int k = 0; k < 4; k++) begin
         resolve(1'b1, 32'h300, 1'b1, 1'b1, 32'h700, 1'b1);
         settle();
      end
      pred_at("t6_sat_hi", 32'h300, BHT);
      resolve(1'b1, 32'h300, 1'b0, 1'b0, 32'h700, 1'b1);
      settle();
      pred_at("t6_dec_once", 32'h300, BHT);
      resolve(1'b1, 32'h300, 1'b0, 1'b0, 32'h700, 1'b1);
      settle();
      pred_at("t6_dec_twice", 32'h300, 1'b0);

      // Randomized traffic, checked by the model each cycle
      for (int n = 0; n < 3000; n++) begin
         rst              = ($urandom_range(0, 63) == 0);
         resolveValid     = $urandom_range(0, 1);
         resolveIsCond    = ($urandom_range(0, 3) != 0);
         resolvePC        = {$urandom_range(0, 3) == 0 ? 24'hFF_FFFF : 24'($urandom),
                             2'($urandom), 4'($urandom), 2'b00};
         resolvePredTaken = $urandom_range(0, 1);
         PCSel            = $urandom_range(0, 1);
         branchPC         = $urandom;
         fetchReady       = $urandom_range(0, 1);
         pc_IF            = {24'($urandom), 2'($urandom), 4'($urandom), 2'b00};
         cyc();
      end
      rst = 1'b0;
      quiet();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
